pp_avg_filter: RTL

- Downstream consumer of the min/max search stage: takes each completed window's signed max/min and its end pulse.
- Per window, computes the instantaneous peak-to-peak value (max-min) and DC offset ((max+min)/2).
- Averages both over 2^AVG_LOG2 windows and emits a one-cycle valid pulse per block, for the amplitude/offset measurement path.

---
 rtl/pp_pkg.sv | 14 +
 rtl/pp_window_calc.sv | 73 +++++++
 rtl/pp_avg_filter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pp_pkg.sv
// Shared types for the peak-to-peak / offset averaging path.
package pp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ACCUM = 3'b010,
        ST_EMIT  = 3'b100
    } pp_state_e;

    function automatic int acc_width(input int data_width, input int avg_log2);
        return data_width + avg_log2;
    endfunction

endpackage

// File: rtl/pp_window_calc.sv
// Stage 1: per-window peak-to-peak and floor-halved offset, with rejection of max < min.
module pp_window_calc
    import pp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        search_max_i,
    input  logic [DATA_WIDTH-1:0]        search_min_i,
    input  logic                         end_pulse_i,
    input  logic                         clear_i,
    output logic [DATA_WIDTH-1:0]        pp_o,
    output logic signed [DATA_WIDTH-1:0] off_o,
    output logic                         valid_o,
    output logic                         bad_o
);

    logic signed [DATA_WIDTH:0]   max_ext, min_ext, diff, sum;
    logic [DATA_WIDTH-1:0]        pp_sat;
    logic                         reject;
    logic                         unused_sum_lsb;

    logic [DATA_WIDTH-1:0]        pp_q, pp_d;
    logic signed [DATA_WIDTH-1:0] off_q, off_d;
    logic                         valid_q, valid_d;
    logic                         bad_q, bad_d;

    assign max_ext = $signed({search_max_i[DATA_WIDTH-1], search_max_i});
    assign min_ext = $signed({search_min_i[DATA_WIDTH-1], search_min_i});
    assign diff    = max_ext - min_ext;
    assign sum     = max_ext + min_ext;
    assign reject  = max_ext < min_ext;
    assign pp_sat  = diff[DATA_WIDTH] ? '1 : diff[DATA_WIDTH-1:0];
    // Dropping the LSB of the widened sum is an arithmetic shift right, i.e. floor.
    assign unused_sum_lsb = sum[0];

    always_comb begin
        pp_d    = pp_q;
        off_d   = off_q;
        valid_d = 1'b0;
        bad_d   = 1'b0;
        if (end_pulse_i && !clear_i) begin
            if (reject) begin
                bad_d = 1'b1;
            end else begin
                pp_d    = pp_sat;
                off_d   = sum[DATA_WIDTH:1];
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_q    <= '0;
            off_q   <= '0;
            valid_q <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            pp_q    <= pp_d;
            off_q   <= off_d;
            valid_q <= valid_d;
            bad_q   <= bad_d;
        end
    end

    assign pp_o    = pp_q;
    assign off_o   = off_q;
    assign valid_o = valid_q;
    assign bad_o   = bad_q;

endmodule

// File: rtl/pp_avg_filter.sv
// Averages per-window peak-to-peak and DC offset over 2^AVG_LOG2 windows.
module pp_avg_filter
    import pp_pkg::*;
#(
    parameter int AVG_LOG2   = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        i_search_max,
    input  logic [DATA_WIDTH-1:0]        i_search_min,
    input  logic                         i_search_end_pulse,
    input  logic                         i_clear,
    input  logic [DATA_WIDTH-1:0]        i_pp_threshold,
    output logic [DATA_WIDTH-1:0]        o_pp_inst,
    output logic [DATA_WIDTH-1:0]        o_pp_avg,
    output logic signed [DATA_WIDTH-1:0] o_offset_avg,
    output logic                         o_avg_valid_pulse,
    output logic                         o_signal_present,
    output logic                         o_bad_window_pulse
);

    localparam int ACC_W = acc_width(DATA_WIDTH, AVG_LOG2);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(1) << AVG_LOG2;

    logic [DATA_WIDTH-1:0]        s1_pp;
    logic signed [DATA_WIDTH-1:0] s1_off;
    logic                         s1_valid;

    pp_window_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_calc (
        .clk          (clk),
        .rst          (rst),
        .search_max_i (i_search_max),
        .search_min_i (i_search_min),
        .end_pulse_i  (i_search_end_pulse),
        .clear_i      (i_clear),
        .pp_o         (s1_pp),
        .off_o        (s1_off),
        .valid_o      (s1_valid),
        .bad_o        (o_bad_window_pulse)
    );

    pp_state_e                    state_q, state_d;
    logic [ACC_W-1:0]             pp_acc_q, pp_acc_d;
    logic signed [ACC_W-1:0]      off_acc_q, off_acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]        pp_avg_q, pp_avg_d;
    logic signed [DATA_WIDTH-1:0] off_avg_q, off_avg_d;
    logic                         vld_q, vld_d;
    logic                         pres_q, pres_d;

    logic [ACC_W-1:0]             pp_ext;
    logic signed [ACC_W-1:0]      off_ext;
    logic [DATA_WIDTH-1:0]        pp_avg_new;
    logic [CNT_W-1:0]             cnt_next;

    assign pp_ext     = ACC_W'(s1_pp);
    assign off_ext    = ACC_W'(s1_off);
    assign pp_avg_new = pp_acc_q[ACC_W-1:AVG_LOG2];

    always_comb begin
        state_d   = state_q;
        pp_acc_d  = pp_acc_q;
        off_acc_d = off_acc_q;
        cnt_d     = cnt_q;
        pp_avg_d  = pp_avg_q;
        off_avg_d = off_avg_q;
        vld_d     = 1'b0;
        pres_d    = pres_q;
        cnt_next  = CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (s1_valid) begin
                    pp_acc_d  = pp_ext;
                    off_acc_d = off_ext;
                end
            end
            ST_ACCUM: begin
                cnt_next = cnt_q + CNT_W'(1);
                if (s1_valid) begin
                    pp_acc_d  = pp_acc_q + pp_ext;
                    off_acc_d = off_acc_q + off_ext;
                end
            end
            ST_EMIT: begin
                pp_avg_d  = pp_avg_new;
                off_avg_d = off_acc_q[ACC_W-1:AVG_LOG2];
                pres_d    = pp_avg_new >= i_pp_threshold;
                vld_d     = 1'b1;
                // A window arriving during EMIT seeds the next block directly.
                if (s1_valid) begin
                    pp_acc_d  = pp_ext;
                    off_acc_d = off_ext;
                end else begin
                    pp_acc_d  = '0;
                    off_acc_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                pp_acc_d  = '0;
                off_acc_d = '0;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end
        endcase

        if (s1_valid && state_q inside {ST_IDLE, ST_ACCUM, ST_EMIT}) begin
            cnt_d   = cnt_next;
            state_d = (cnt_next == N_CNT) ? ST_EMIT : ST_ACCUM;
        end

        if (i_clear) begin
            pp_acc_d  = '0;
            off_acc_d = '0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pp_acc_q  <= '0;
            off_acc_q <= '0;
            cnt_q     <= '0;
            pp_avg_q  <= '0;
            off_avg_q <= '0;
            vld_q     <= 1'b0;
            pres_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pp_acc_q  <= pp_acc_d;
            off_acc_q <= off_acc_d;
            cnt_q     <= cnt_d;
            pp_avg_q  <= pp_avg_d;
            off_avg_q <= off_avg_d;
            vld_q     <= vld_d;
            pres_q    <= pres_d;
        end
    end

    assign o_pp_inst         = s1_pp;
    assign o_pp_avg          = pp_avg_q;
    assign o_offset_avg      = off_avg_q;
    assign o_avg_valid_pulse = vld_q;
    assign o_signal_present  = pres_q;

endmodule
